l2_flush_seq: RTL and testbench
===============================

L2_FLUSH_SEQ -- requirements
Module: l2_flush_seq

Interface
REQ-001 SHALL have parameter N_SETS, default 256: number of L2 sets, a power of two.
REQ-002 SHALL have parameter N_WAYS, default 8: number of L2 ways, a power of two.
REQ-003 SHALL have parameter N_REQS, default 4: number of outstanding-request entries.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_req  in  1  start request, sampled only in IDLE.
REQ-007 SHALL have port flush_is_wb  in  1  1 = write-back only, 0 = write-back and invalidate; latched at start.
REQ-008 SHALL have port flush_set  in  SET_BITS+1  current set index, from the flush counter register.
REQ-009 SHALL have port flush_way  in  WAY_BITS+1  current way index, from the flush counter register.
REQ-010 SHALL have port reqs_cnt  in  REQS_BITS_P1  number of free request entries.
REQ-011 SHALL have ports set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set, incr_flush_way, clr_flush_way  out  1 each  single-cycle register-control pulses.
REQ-012 SHALL have ports rd_req_valid out 1 and rd_req_ready in 1  tag/state read handshake for (flush_set, flush_way).
REQ-013 SHALL have ports rd_rsp_valid in 1 and rd_rsp_state in 2  line state: 0 INVALID, 1 SHARED, 2 EXCLUSIVE, 3 MODIFIED.
REQ-014 SHALL have ports evict_valid out 1, evict_ready in 1, evict_set out SET_BITS, evict_way out WAY_BITS, evict_wb out 1, evict_inv out 1  eviction request.
REQ-015 SHALL have port fill_reqs_flush  out  1  pulse that allocates one request entry.
REQ-016 SHALL have port flush_done  out  1  single-cycle completion pulse.

Function
REQ-017 SHALL implement the FSM states IDLE, READ, WAIT_RSP, EVICT, NEXT, DRAIN and DONE.
REQ-018 IDLE with flush_req=1 SHALL, in one cycle, pulse set_ongoing_flush, clr_flush_set and clr_flush_way, latch flush_is_wb, and move to READ; while not in IDLE, flush_req SHALL be ignored.
REQ-019 READ SHALL hold rd_req_valid=1; the rd_req_valid && rd_req_ready transfer SHALL move to WAIT_RSP.
REQ-020 WAIT_RSP with rd_rsp_valid SHALL go to NEXT if the state is INVALID, or if latched wb=1 and the state is not MODIFIED; otherwise it SHALL go to EVICT.
REQ-021 EVICT SHALL assert evict_valid only while reqs_cnt != 0.
REQ-022 In EVICT, evict_set and evict_way SHALL equal the low bits of flush_set and flush_way.
REQ-023 In EVICT, evict_wb SHALL equal (state == MODIFIED) and evict_inv SHALL equal !latched_wb.
REQ-024 The EVICT transfer SHALL pulse fill_reqs_flush in the same cycle and move to NEXT.
REQ-025 NEXT with flush_way == N_WAYS-1 SHALL pulse clr_flush_way and incr_flush_set, then go to DRAIN if flush_set == N_SETS-1, else to READ.
REQ-026 NEXT with flush_way < N_WAYS-1 SHALL pulse incr_flush_way and go to READ.
REQ-027 DRAIN SHALL wait until reqs_cnt == N_REQS, then go to DONE.
REQ-028 DONE SHALL pulse clr_ongoing_flush and flush_done, then return to IDLE.
REQ-029 Each control pulse SHALL be asserted for exactly one cycle per visit to its state; no two of incr/clr for the same counter SHALL ever be asserted together.
REQ-030 evict_valid and rd_req_valid, once asserted, SHALL remain asserted until accepted.
REQ-031 The EVICT payload SHALL stay stable while evict_valid is asserted.
REQ-032 The captured state SHALL be registered and SHALL be held from WAIT_RSP through EVICT.
REQ-033 rd_rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-034 All comparisons SHALL be unsigned; set and way indices SHALL use the low SET_BITS and WAY_BITS bits.

Reset
REQ-035 rst low SHALL force IDLE, all outputs to 0 and latched_wb and the captured state to 0, immediately, including mid-flush.
REQ-036 No pulse SHALL be emitted in the first cycle after reset release.

Structure
REQ-037 The line-state encoding, the FSM state enum, and the SET_BITS, WAY_BITS, REQS_BITS_P1 constants SHALL live in the shared cache package/headers.
REQ-038 The block SHALL be a single module with no sub-module; the counters SHALL remain in the external register block.

Verification
The bench SHALL use N_SETS=4, N_WAYS=2, N_REQS=4, with a model of the external counters.
REQ-039 All-INVALID lines, wb=0 -> 8 reads, 0 evicts, flush_done pulses exactly once, then clr_ongoing_flush.
REQ-040 Set 2/way 1 MODIFIED, wb=1 -> exactly one evict with set=2, way=1, wb=1, inv=0, plus one fill_reqs_flush pulse.
REQ-041 All lines SHARED, wb=0 -> 8 evicts with wb=0, inv=1, in set-major, way-minor order.
REQ-042 reqs_cnt held 0 in EVICT for 10 cycles -> evict_valid stays low; it asserts the cycle reqs_cnt becomes 1; DRAIN holds until reqs_cnt=4.
REQ-043 flush_req re-asserted mid-flush -> ignored; rst pulled low in EVICT -> all outputs 0, IDLE on release, no spurious pulses.
REQ-044 evict_ready delayed 5 cycles -> evict_set, evict_way, evict_wb and evict_inv stay stable.

Source files
------------

// File: rtl/l2_flush_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2_flush_seq_pkg -- shared L2 line-state/FSM encodings and index widths
// Revision: 1.0
// ---------------------------------------------------------------------------
package l2_flush_seq_pkg;

  localparam int SET_BITS     = 8;
  localparam int WAY_BITS     = 3;
  localparam int REQS_BITS_P1 = 3;

  typedef enum logic [1:0] {
    LS_INVALID   = 2'd0,
    LS_SHARED    = 2'd1,
    LS_EXCLUSIVE = 2'd2,
    LS_MODIFIED  = 2'd3
  } line_state_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_EVICT    = 3'd3,
    ST_NEXT     = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_DONE     = 3'd6
  } flush_state_e;

  // Write-back-only flushes leave clean valid lines in place.
  function automatic logic needs_evict(input line_state_e state, input logic wb_only);
    return (state != LS_INVALID) && !(wb_only && (state != LS_MODIFIED));
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_flush_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2_flush_seq_if -- tag/state read and eviction handshakes of the flush sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
interface l2_flush_seq_if;
  import l2_flush_seq_pkg::*;

  logic                rd_req_valid;
  logic                rd_req_ready;
  logic                rd_rsp_valid;
  logic [1:0]          rd_rsp_state;
  logic                evict_valid;
  logic                evict_ready;
  logic [SET_BITS-1:0] evict_set;
  logic [WAY_BITS-1:0] evict_way;
  logic                evict_wb;
  logic                evict_inv;

  modport master (
    output rd_req_valid, input rd_req_ready,
    input  rd_rsp_valid, input rd_rsp_state,
    output evict_valid,  input evict_ready,
    output evict_set, output evict_way, output evict_wb, output evict_inv
  );

  modport slave (
    input  rd_req_valid, output rd_req_ready,
    output rd_rsp_valid, output rd_rsp_state,
    input  evict_valid,  output evict_ready,
    input  evict_set, input evict_way, input evict_wb, input evict_inv
  );

endinterface
`default_nettype wire

// File: rtl/l2_flush_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2_flush_seq -- walks every L2 set/way, evicting lines that the flush mode requires
// Revision: 1.0
// ---------------------------------------------------------------------------
module l2_flush_seq
  import l2_flush_seq_pkg::*;
#(
  parameter int N_SETS = 256,
  parameter int N_WAYS = 8,
  parameter int N_REQS = 4
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    flush_req,
  input  wire logic                    flush_is_wb,
  input  wire logic [SET_BITS:0]       flush_set,
  input  wire logic [WAY_BITS:0]       flush_way,
  input  wire logic [REQS_BITS_P1-1:0] reqs_cnt,
  output logic                         set_ongoing_flush,
  output logic                         clr_ongoing_flush,
  output logic                         incr_flush_set,
  output logic                         clr_flush_set,
  output logic                         incr_flush_way,
  output logic                         clr_flush_way,
  output logic                         fill_reqs_flush,
  output logic                         flush_done,
  l2_flush_seq_if.master               bus
);

  flush_state_e        r_state;
  logic                r_latched_wb;
  line_state_e         r_cap_state;
  logic                r_rd_req_valid;
  logic                r_evict_shown;
  logic [SET_BITS-1:0] r_evict_set;
  logic [WAY_BITS-1:0] r_evict_way;
  logic                r_evict_inv;
  logic                r_set_ongoing_flush;
  logic                r_clr_ongoing_flush;
  logic                r_incr_flush_set;
  logic                r_clr_flush_set;
  logic                r_incr_flush_way;
  logic                r_clr_flush_way;
  logic                r_flush_done;

  logic w_last_way;
  logic w_last_set;
  logic w_need_evict;
  logic w_evict_valid;
  logic w_evict_fire;
  logic w_rd_fire;
  logic w_to_next;
  logic w_unused_msb;

  assign w_last_way    = (flush_way[WAY_BITS-1:0] == WAY_BITS'(N_WAYS - 1));
  assign w_last_set    = (flush_set[SET_BITS-1:0] == SET_BITS'(N_SETS - 1));
  assign w_need_evict  = needs_evict(line_state_e'(bus.rd_rsp_state), r_latched_wb);
  // Once shown, the eviction stays valid even if the free-entry count dips.
  assign w_evict_valid = (r_state == ST_EVICT) && ((reqs_cnt != '0) || r_evict_shown);
  assign w_evict_fire  = w_evict_valid && bus.evict_ready;
  assign w_rd_fire     = r_rd_req_valid && bus.rd_req_ready;
  assign w_to_next     = ((r_state == ST_WAIT_RSP) && bus.rd_rsp_valid && !w_need_evict)
                       || w_evict_fire;
  assign w_unused_msb  = flush_set[SET_BITS] ^ flush_way[WAY_BITS];

  // rd_req_valid rises one cycle into READ so the counter update from the
  // preceding pulse has landed before the address is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state             <= ST_IDLE;
      r_latched_wb        <= 1'b0;
      r_cap_state         <= LS_INVALID;
      r_rd_req_valid      <= 1'b0;
      r_evict_shown       <= 1'b0;
      r_evict_set         <= '0;
      r_evict_way         <= '0;
      r_evict_inv         <= 1'b0;
      r_set_ongoing_flush <= 1'b0;
      r_clr_ongoing_flush <= 1'b0;
      r_incr_flush_set    <= 1'b0;
      r_clr_flush_set     <= 1'b0;
      r_incr_flush_way    <= 1'b0;
      r_clr_flush_way     <= 1'b0;
      r_flush_done        <= 1'b0;
    end else begin
      r_set_ongoing_flush <= 1'b0;
      r_clr_ongoing_flush <= 1'b0;
      r_incr_flush_set    <= 1'b0;
      r_clr_flush_set     <= 1'b0;
      r_incr_flush_way    <= 1'b0;
      r_clr_flush_way     <= 1'b0;
      r_flush_done        <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (flush_req) begin
            r_set_ongoing_flush <= 1'b1;
            r_clr_flush_set     <= 1'b1;
            r_clr_flush_way     <= 1'b1;
            r_latched_wb        <= flush_is_wb;
            r_state             <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_rd_fire) begin
            r_rd_req_valid <= 1'b0;
            r_state        <= ST_WAIT_RSP;
          end else begin
            r_rd_req_valid <= 1'b1;
          end
        end
        ST_WAIT_RSP: begin
          if (bus.rd_rsp_valid) begin
            r_cap_state <= line_state_e'(bus.rd_rsp_state);
            if (w_need_evict) begin
              r_evict_set <= flush_set[SET_BITS-1:0];
              r_evict_way <= flush_way[WAY_BITS-1:0];
              r_evict_inv <= !r_latched_wb;
              r_state     <= ST_EVICT;
            end else begin
              r_state     <= ST_NEXT;
            end
          end
        end
        ST_EVICT: begin
          if (w_evict_fire) begin
            r_evict_shown <= 1'b0;
            r_state       <= ST_NEXT;
          end else if (w_evict_valid) begin
            r_evict_shown <= 1'b1;
          end
        end
        ST_NEXT: begin
          r_state <= (w_last_way && w_last_set) ? ST_DRAIN : ST_READ;
        end
        ST_DRAIN: begin
          if (reqs_cnt == REQS_BITS_P1'(N_REQS)) begin
            r_clr_ongoing_flush <= 1'b1;
            r_flush_done        <= 1'b1;
            r_state             <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      // Counter-advance pulses land in NEXT, which still sees the old indices.
      if (w_to_next) begin
        if (w_last_way) begin
          r_clr_flush_way  <= 1'b1;
          r_incr_flush_set <= 1'b1;
        end else begin
          r_incr_flush_way <= 1'b1;
        end
      end
    end
  end

  assign set_ongoing_flush = r_set_ongoing_flush;
  assign clr_ongoing_flush = r_clr_ongoing_flush;
  assign incr_flush_set    = r_incr_flush_set;
  assign clr_flush_set     = r_clr_flush_set;
  assign incr_flush_way    = r_incr_flush_way;
  assign clr_flush_way     = r_clr_flush_way;
  assign flush_done        = r_flush_done;
  assign fill_reqs_flush   = w_evict_fire;

  assign bus.rd_req_valid  = r_rd_req_valid;
  assign bus.evict_valid   = w_evict_valid;
  assign bus.evict_set     = r_evict_set;
  assign bus.evict_way     = r_evict_way;
  assign bus.evict_wb      = (r_cap_state == LS_MODIFIED);
  assign bus.evict_inv     = r_evict_inv;

endmodule
`default_nettype wire

// File: tb/tb_l2_flush_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_l2_flush_seq -- directed vectors and corner sequences for l2_flush_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_l2_flush_seq;
  import l2_flush_seq_pkg::*;

  localparam int NS = 4;
  localparam int NW = 2;
  localparam int NR = 4;
  localparam int OW = 12 + SET_BITS + WAY_BITS;

  typedef struct {
    int set;
    int way;
    bit wb;
    bit inv;
  } ev_t;

  typedef struct {
    string       name;
    logic [15:0] lines;
    logic        wb;
    int          exp_ev;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    flush_req   = 1'b0;
  logic                    flush_is_wb = 1'b0;
  logic [SET_BITS:0]       flush_set;
  logic [WAY_BITS:0]       flush_way;
  logic [REQS_BITS_P1-1:0] reqs_cnt;
  logic set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set;
  logic incr_flush_way, clr_flush_way, fill_reqs_flush, flush_done;

  l2_flush_seq_if bus();

  l2_flush_seq #(.N_SETS(NS), .N_WAYS(NW), .N_REQS(NR)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .flush_is_wb(flush_is_wb),
    .flush_set(flush_set), .flush_way(flush_way), .reqs_cnt(reqs_cnt),
    .set_ongoing_flush(set_ongoing_flush), .clr_ongoing_flush(clr_ongoing_flush),
    .incr_flush_set(incr_flush_set), .clr_flush_set(clr_flush_set),
    .incr_flush_way(incr_flush_way), .clr_flush_way(clr_flush_way),
    .fill_reqs_flush(fill_reqs_flush), .flush_done(flush_done), .bus(bus)
  );

  // External counter register block and free-entry pool
  logic ongoing;
  logic manual_reqs = 1'b0;
  logic [REQS_BITS_P1-1:0] manual_cnt = REQS_BITS_P1'(NR);
  logic [REQS_BITS_P1-1:0] auto_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_set <= '0;
      flush_way <= '0;
      ongoing   <= 1'b0;
      auto_cnt  <= REQS_BITS_P1'(NR);
    end else begin
      if (clr_flush_set) flush_set <= '0;
      else if (incr_flush_set) flush_set <= flush_set + 1'b1;
      if (clr_flush_way) flush_way <= '0;
      else if (incr_flush_way) flush_way <= flush_way + 1'b1;
      if (set_ongoing_flush) ongoing <= 1'b1;
      else if (clr_ongoing_flush) ongoing <= 1'b0;
      auto_cnt <= fill_reqs_flush ? REQS_BITS_P1'(NR - 1) : REQS_BITS_P1'(NR);
    end
  end
  assign reqs_cnt = manual_reqs ? manual_cnt : auto_cnt;

  // Tag array responder: one-cycle read latency
  logic [1:0] mem [8];
  logic       rsp_v;
  logic [1:0] rsp_s;
  logic       rd_ready = 1'b1;
  logic       ev_ready = 1'b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_v <= 1'b0;
      rsp_s <= 2'd0;
    end else begin
      rsp_v <= bus.rd_req_valid && bus.rd_req_ready;
      if (bus.rd_req_valid && bus.rd_req_ready)
        rsp_s <= mem[int'(flush_set[1:0]) * NW + int'(flush_way[0])];
    end
  end
  assign bus.rd_req_ready = rd_ready;
  assign bus.rd_rsp_valid = rsp_v;
  assign bus.rd_rsp_state = rsp_s;
  assign bus.evict_ready  = ev_ready;

  logic [OW-1:0] outs;
  assign outs = {set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set,
                 incr_flush_way, clr_flush_way, bus.rd_req_valid, bus.evict_valid,
                 bus.evict_set, bus.evict_way, bus.evict_wb, bus.evict_inv,
                 fill_reqs_flush, flush_done};

  // Protocol monitor
  int n_reads = 0, n_fill = 0, n_done = 0, n_clr_on = 0, n_set_on = 0, n_viol = 0;
  ev_t evq[$];
  ev_t e;
  logic [6:0] p, prev_p;
  logic [SET_BITS+WAY_BITS+1:0] payload, prev_payload;
  logic prev_ev_stall, prev_rd_stall;
  always @(negedge clk) begin
    if (!rst) begin
      prev_p        = '0;
      prev_ev_stall = 1'b0;
      prev_rd_stall = 1'b0;
    end else begin
      p = {set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set,
           incr_flush_way, clr_flush_way, flush_done};
      payload = {bus.evict_set, bus.evict_way, bus.evict_wb, bus.evict_inv};
      if ((p & prev_p) != '0) n_viol++;
      if ((incr_flush_set && clr_flush_set) || (incr_flush_way && clr_flush_way)) n_viol++;
      if (fill_reqs_flush != (bus.evict_valid && bus.evict_ready)) n_viol++;
      if (prev_ev_stall && (!bus.evict_valid || payload != prev_payload)) n_viol++;
      if (prev_rd_stall && !bus.rd_req_valid) n_viol++;
      if (bus.rd_req_valid && bus.rd_req_ready) n_reads++;
      if (bus.evict_valid && bus.evict_ready) begin
        e.set = int'(bus.evict_set);
        e.way = int'(bus.evict_way);
        e.wb  = bus.evict_wb;
        e.inv = bus.evict_inv;
        evq.push_back(e);
      end
      if (fill_reqs_flush)   n_fill++;
      if (flush_done)        n_done++;
      if (clr_ongoing_flush) n_clr_on++;
      if (set_ongoing_flush) n_set_on++;
      prev_p        = p;
      prev_payload  = payload;
      prev_ev_stall = bus.evict_valid && !bus.evict_ready;
      prev_rd_stall = bus.rd_req_valid && !bus.rd_req_ready;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] lines);
    for (int i = 0; i < 8; i++) mem[i] = lines[2*i +: 2];
  endtask

  task automatic start(input logic wb);
    flush_is_wb = wb;
    flush_req   = 1'b1;
    cyc(1);
    flush_req   = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    int t = 0;
    while (n_done == base && t < 1000) begin
      cyc(1);
      t++;
    end
    chk(name, int'(n_done != base), 1);
  endtask

  task automatic wait_evict_valid(input string name);
    int t = 0;
    while (!bus.evict_valid && t < 200) begin
      cyc(1);
      t++;
    end
    chk(name, int'(bus.evict_valid), 1);
  endtask

  // Compares the captured evictions against a set-major/way-minor scan of mem.
  task automatic check_order(input string name, input int base, input logic wb);
    int k = base;
    int bad = 0;
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin
        logic [1:0] st;
        st = mem[s*NW + w];
        if (st != 2'd0 && !(wb && st != 2'd3)) begin
          if (k >= evq.size()) bad++;
          else if (evq[k].set != s || evq[k].way != w || evq[k].wb != (st == 2'd3) || evq[k].inv != !wb) bad++;
          k++;
        end
      end
    end
    if (k != evq.size()) bad++;
    chk(name, bad, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int b_rd, b_ev, b_fill, b_done, b_clr, b_set, b_viol, bad;

    vecs[0] = '{name: "all_invalid",  lines: 16'h0000, wb: 1'b0, exp_ev: 0};
    vecs[1] = '{name: "s2w1_mod_wb",  lines: 16'h0C00, wb: 1'b1, exp_ev: 1};
    vecs[2] = '{name: "all_shared",   lines: 16'h5555, wb: 1'b0, exp_ev: 8};
    vecs[3] = '{name: "shared_wb",    lines: 16'h5555, wb: 1'b1, exp_ev: 0};
    vecs[4] = '{name: "mixed_wb",     lines: 16'h631B, wb: 1'b1, exp_ev: 2};
    vecs[5] = '{name: "mixed_inv",    lines: 16'h631B, wb: 1'b0, exp_ev: 6};

    load(16'h0000);
    #2 rst = 1'b0;
    cyc(3);
    chk("reset_outputs", int'(outs), 0);
    rst = 1'b1;
    cyc(1);
    chk("post_reset_outputs", int'(outs), 0);
    cyc(2);

    for (int v = 0; v < 6; v++) begin
      load(vecs[v].lines);
      b_rd = n_reads; b_ev = evq.size(); b_fill = n_fill; b_done = n_done;
      b_clr = n_clr_on; b_set = n_set_on; b_viol = n_viol;
      start(vecs[v].wb);
      wait_done(b_done, {vecs[v].name, "_done_seen"});
      cyc(3);
      chk({vecs[v].name, "_reads"},   n_reads - b_rd, NS * NW);
      chk({vecs[v].name, "_evicts"},  evq.size() - b_ev, vecs[v].exp_ev);
      chk({vecs[v].name, "_fills"},   n_fill - b_fill, vecs[v].exp_ev);
      chk({vecs[v].name, "_done_n"},  n_done - b_done, 1);
      chk({vecs[v].name, "_clr_on"},  n_clr_on - b_clr, 1);
      chk({vecs[v].name, "_set_on"},  n_set_on - b_set, 1);
      chk({vecs[v].name, "_ongoing"}, int'(ongoing), 0);
      chk({vecs[v].name, "_end_set"}, int'(flush_set), NS);
      chk({vecs[v].name, "_end_way"}, int'(flush_way), 0);
      chk({vecs[v].name, "_protocol"}, n_viol - b_viol, 0);
      check_order({vecs[v].name, "_order"}, b_ev, vecs[v].wb);
    end

    // No free entries while EVICT is pending, then a partial drain
    load(16'h0030);
    manual_reqs = 1'b1;
    manual_cnt  = '0;
    b_rd = n_reads; b_ev = evq.size(); b_done = n_done; b_viol = n_viol;
    start(1'b0);
    begin
      int t = 0;
      while (n_reads - b_rd < 3 && t < 200) begin
        cyc(1);
        t++;
      end
    end
    cyc(1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.evict_valid) bad++;
      cyc(1);
    end
    chk("nocredit_evict_low", bad, 0);
    manual_cnt = REQS_BITS_P1'(1);
    #1;
    chk("credit_evict_valid", int'(bus.evict_valid), 1);
    chk("credit_payload", int'(bus.evict_set == 1 && bus.evict_way == 0 && bus.evict_wb && bus.evict_inv), 1);
    chk("credit_fill", int'(fill_reqs_flush), 1);
    cyc(1);
    manual_cnt = REQS_BITS_P1'(3);
    cyc(60);
    chk("drain_holds", n_done - b_done, 0);
    manual_cnt = REQS_BITS_P1'(NR);
    wait_done(b_done, "drain_release");
    manual_reqs = 1'b0;
    cyc(3);
    chk("credit_evicts", evq.size() - b_ev, 1);
    chk("credit_protocol", n_viol - b_viol, 0);

    // Eviction back-pressure: payload must hold
    load(16'h8000);
    ev_ready = 1'b0;
    b_ev = evq.size(); b_done = n_done; b_viol = n_viol;
    start(1'b0);
    wait_evict_valid("stall_evict_seen");
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!(bus.evict_valid && bus.evict_set == 3 && bus.evict_way == 1 && !bus.evict_wb && bus.evict_inv)) bad++;
      cyc(1);
    end
    chk("stall_payload_stable", bad, 0);
    ev_ready = 1'b1;
    wait_done(b_done, "stall_done");
    cyc(3);
    chk("stall_evicts", evq.size() - b_ev, 1);
    chk("stall_protocol", n_viol - b_viol, 0);

    // flush_req re-asserted mid-flush with the other mode
    load(16'h5555);
    b_ev = evq.size(); b_done = n_done; b_set = n_set_on; b_rd = n_reads;
    start(1'b0);
    cyc(12);
    flush_req   = 1'b1;
    flush_is_wb = 1'b1;
    cyc(2);
    flush_req   = 1'b0;
    wait_done(b_done, "retrigger_done");
    cyc(3);
    chk("retrigger_set_on", n_set_on - b_set, 1);
    chk("retrigger_reads", n_reads - b_rd, NS * NW);
    chk("retrigger_evicts", evq.size() - b_ev, 8);
    bad = 0;
    for (int i = b_ev; i < evq.size(); i++) if (!evq[i].inv || evq[i].wb) bad++;
    chk("retrigger_latched_mode", bad, 0);

    // Reset pulled while an eviction is stalled
    load(16'hFFFF);
    ev_ready = 1'b0;
    b_done = n_done; b_viol = n_viol;
    start(1'b1);
    wait_evict_valid("rst_evict_seen");
    rst = 1'b0;
    #1;
    chk("rst_mid_outputs", int'(outs), 0);
    cyc(2);
    ev_ready = 1'b1;
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (outs != '0) bad++;
      cyc(1);
    end
    chk("rst_release_quiet", bad, 0);
    chk("rst_no_done", n_done - b_done, 0);
    chk("rst_protocol", n_viol - b_viol, 0);

    load(16'h0000);
    b_done = n_done; b_rd = n_reads;
    start(1'b0);
    wait_done(b_done, "post_rst_done");
    cyc(3);
    chk("post_rst_reads", n_reads - b_rd, NS * NW);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
